// File: rtl/instr_assembler.sv
// -----------------------------------------------------------------------------
// instr_assembler
//
// Purpose:
//   Accepts instruction field requests (R/I/J format) one at a time, packs them
//   into 32-bit instruction words and writes them sequentially into an
//   instruction memory through a simple write/ack port. After DEPTH words have
//   been written the block parks in FULL until clear is asserted.
//
// Configuration:
//   ENC_FIELD_CHECK_EN - when defined, an accept whose used fields carry a
//                        nonzero padding bit is rejected like a reserved
//                        format (err pulse, no write). When undefined, the
//                        padding bits are silently dropped.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready - field request handshake (ready only in IDLE)
//   fmt               - 00 R, 01 I, 10 J, 11 reserved
//   opcode, fn        - 6-bit opcode and function fields
//   rs, rt, rd, sh    - 6-bit register/shift fields (bit 5 is padding)
//   imm               - 17-bit immediate (bit 16 is padding)
//   jump              - 26-bit jump target
//   mem_we/mem_addr/mem_wdata/mem_ack - memory write port
//   clear             - synchronous restart of the write sequence
//   full              - DEPTH words have been written
//   count             - number of words written since reset/clear
//   err               - one-cycle pulse on a rejected accept
// -----------------------------------------------------------------------------
module instr_assembler #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [5:0]        fn,
  input  logic [5:0]        rs,
  input  logic [5:0]        rt,
  input  logic [5:0]        rd,
  input  logic [5:0]        sh,
  input  logic [16:0]       imm,
  input  logic [25:0]       jump,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic              clear,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;

  logic [31:0]         packed_word;
  logic                fmt_bad;
  logic                pad_bad;
  logic [ADDR_W:0]     count_inc;

  // Field packing; reserved format yields zero (never written anyway).
  always_comb begin
    packed_word = '0;
    case (fmt)
      2'b00:   packed_word = {opcode, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
      2'b01:   packed_word = {opcode, rs[4:0], rt[4:0], imm[15:0]};
      2'b10:   packed_word = {opcode, jump};
      default: packed_word = '0;
    endcase
  end

  assign fmt_bad = (fmt == 2'b11);

`ifdef ENC_FIELD_CHECK_EN
  // Only the padding bits of fields the format actually uses are checked.
  always_comb begin
    pad_bad = 1'b0;
    case (fmt)
      2'b00:   pad_bad = rs[5] | rt[5] | rd[5] | sh[5];
      2'b01:   pad_bad = rs[5] | rt[5] | imm[16];
      default: pad_bad = 1'b0;
    endcase
  end
`else
  logic unused_pad;
  assign pad_bad    = 1'b0;
  // Padding bits are intentionally dropped in this build.
  assign unused_pad = ^{rs[5], rt[5], rd[5], sh[5], imm[16]};
`endif

  assign count_inc = count_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = 1'b0;

    if (clear) begin
      // Clear dominates everything, including a same-edge ack.
      state_d = IDLE;
      addr_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (fmt_bad || pad_bad) begin
              err_d = 1'b1;
            end else begin
              wdata_d = packed_word;
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            count_d = count_inc;
            if (count_inc == (ADDR_W+1)'(DEPTH)) begin
              state_d = FULL;
              addr_d  = '0;
            end else begin
              state_d = IDLE;
              addr_d  = addr_q + ADDR_W'(1);
            end
          end
        end
        FULL: begin
          state_d = FULL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // All outputs decode directly from registered state, so reset drops
  // mem_we immediately without waiting for a clock.
  assign in_ready  = (state_q == IDLE);
  assign mem_we    = (state_q == WRITE);
  assign full      = (state_q == FULL);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_assembler.sv
module tb_instr_assembler;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode, fn, rs, rt, rd, sh;
  logic [16:0]       imm;
  logic [25:0]       jump;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic              clear;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              err;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t sb[$];

  instr_assembler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .fn(fn),
    .rs(rs), .rt(rt), .rd(rd), .sh(sh),
    .imm(imm), .jump(jump),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .clear(clear), .full(full), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packing of the instruction formats.
  function automatic logic [31:0] model_pack(input logic [1:0] f, input logic [5:0] op,
      input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] s,
      input logic [5:0] fu, input logic [16:0] im, input logic [25:0] jp);
    case (f)
      2'b00:   return {op, a[4:0], b[4:0], c[4:0], s[4:0], fu};
      2'b01:   return {op, a[4:0], b[4:0], im[15:0]};
      2'b10:   return {op, jp};
      default: return 32'h0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [1:0] f, input logic [5:0] op, input logic [5:0] a,
      input logic [5:0] b, input logic [5:0] c, input logic [5:0] s, input logic [5:0] fu,
      input logic [16:0] im, input logic [25:0] jp);
    fmt = f; opcode = op; rs = a; rt = b; rd = c; sh = s; fn = fu; imm = im; jump = jp;
    in_valid = 1'b1;
    chk("in_ready_at_accept", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks the pending write against the scoreboard, holds ack low for
  // 'hold' cycles checking stability, then acks.
  task automatic serve(input int hold);
    wr_t e;
    chk("mem_we_after_accept", mem_we, 1'b1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.data);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_we", mem_we, 1'b1);
        chk("hold_addr", mem_addr, e.addr);
        chk("hold_wdata", mem_wdata, e.data);
      end
    end
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  initial begin
    wr_t w;
    logic [5:0]  ra, rb, rc, rs5, op, fu;
    logic [1:0]  f;
    logic [16:0] im;
    logic [25:0] jp;

    rst_n = 1'b0; in_valid = 1'b0; mem_ack = 1'b0; clear = 1'b0;
    fmt = 2'b00; opcode = '0; fn = '0; rs = '0; rt = '0; rd = '0; sh = '0;
    imm = '0; jump = '0;

    // Reset values
    #1;
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_count", count, '0);
    chk("rst_full", full, 1'b0);
    chk("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1'b1);

    // R format, immediate ack, then back-to-back readiness
    w.addr = 6'd0; w.data = 32'h00221820; sb.push_back(w);
    accept(2'b00, 6'h00, 6'd1, 6'd2, 6'd3, 6'd0, 6'h20, 17'h0, 26'h0);
    serve(0);
    chk("ready_after_ack", in_ready, 1'b1);
    chk("count_1", count, 7'd1);

    // I format
    w.addr = 6'd1; w.data = 32'h20220005; sb.push_back(w);
    accept(2'b01, 6'h08, 6'd1, 6'd2, 6'd0, 6'd0, 6'h00, 17'h00005, 26'h0);
    serve(0);

    // J format with 5 stalled cycles
    w.addr = 6'd2; w.data = 32'h08000010; sb.push_back(w);
    accept(2'b10, 6'h02, 6'd0, 6'd0, 6'd0, 6'd0, 6'h00, 17'h0, 26'h0000010);
    serve(5);
    chk("count_3", count, 7'd3);
    exp_count = 3;

    // Reserved format
    accept(2'b11, 6'h3f, 6'd1, 6'd2, 6'd3, 6'd4, 6'h05, 17'h1, 26'h1);
    chk("fmt11_err", err, 1'b1);
    chk("fmt11_no_we", mem_we, 1'b0);
    @(negedge clk);
    chk("fmt11_err_drop", err, 1'b0);
    chk("fmt11_idle", in_ready, 1'b1);
    chk("fmt11_count", count, 7'd3);

    // Nonzero padding bit in rs
`ifdef ENC_FIELD_CHECK_EN
    accept(2'b00, 6'h00, 6'h21, 6'd2, 6'd3, 6'd0, 6'h20, 17'h0, 26'h0);
    chk("pad_err", err, 1'b1);
    chk("pad_no_we", mem_we, 1'b0);
    @(negedge clk);
    chk("pad_err_drop", err, 1'b0);
`else
    w.addr = 6'd3; w.data = 32'h00221820; sb.push_back(w);
    accept(2'b00, 6'h00, 6'h21, 6'd2, 6'd3, 6'd0, 6'h20, 17'h0, 26'h0);
    chk("pad_no_err", err, 1'b0);
    serve(0);
    exp_count = 4;
`endif
    chk("pad_count", count, exp_count[ADDR_W:0]);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_count", count, exp_count[ADDR_W:0]);
    chk("idle_ack_we", mem_we, 1'b0);

    // Clear and ack on the same edge: clear wins
    accept(2'b00, 6'h01, 6'd4, 6'd5, 6'd6, 6'd7, 6'h08, 17'h0, 26'h0);
    chk("pre_clear_we", mem_we, 1'b1);
    clear = 1'b1; mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; mem_ack = 1'b0;
    chk("clr_ack_count", count, '0);
    chk("clr_ack_we", mem_we, 1'b0);
    chk("clr_ack_addr", mem_addr, '0);
    chk("clr_ack_ready", in_ready, 1'b1);

    // Fill all DEPTH words
    for (int i = 0; i < DEPTH; i++) begin
      f   = 2'($urandom_range(0, 2));
      op  = 6'($urandom_range(0, 63));
      ra  = 6'($urandom_range(0, 31));
      rb  = 6'($urandom_range(0, 31));
      rc  = 6'($urandom_range(0, 31));
      rs5 = 6'($urandom_range(0, 31));
      fu  = 6'($urandom_range(0, 63));
      im  = 17'($urandom_range(0, 65535));
      jp  = 26'($urandom);
      w.addr = 6'(i);
      w.data = model_pack(f, op, ra, rb, rc, rs5, fu, im, jp);
      sb.push_back(w);
      accept(f, op, ra, rb, rc, rs5, fu, im, jp);
      serve(0);
    end
    chk("full_count", count, 7'd64);
    chk("full_flag", full, 1'b1);
    chk("full_not_ready", in_ready, 1'b0);
    chk("full_addr", mem_addr, '0);

    // in_valid ignored while full
    fmt = 2'b00; rs = 6'd1; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("full_ignore_we", mem_we, 1'b0);
    chk("full_ignore_count", count, 7'd64);
    chk("full_stays", full, 1'b1);

    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("clear_count", count, '0);
    chk("clear_ready", in_ready, 1'b1);
    chk("clear_full", full, 1'b0);

    // Asynchronous reset during a pending write
    w.addr = 6'd0; w.data = 32'h08000010; sb.push_back(w);
    accept(2'b10, 6'h02, 6'd0, 6'd0, 6'd0, 6'd0, 6'h00, 17'h0, 26'h0000010);
    serve(0);
    accept(2'b10, 6'h03, 6'd0, 6'd0, 6'd0, 6'd0, 6'h00, 17'h0, 26'h0000020);
    chk("prereset_we", mem_we, 1'b1);
    chk("prereset_count", count, 7'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we", mem_we, 1'b0);
    chk("async_rst_count", count, '0);
    chk("async_rst_addr", mem_addr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
